// File: rtl/gate_arm_ctrl.sv
// gate_arm_ctrl: entry gate-arm motor controller.
// Turns the lot FSM status and the gate sensors into registered Up/Down motor
// commands. Provides a safety reverse on obstruction and a sticky fault when
// a motor move does not reach its limit switch in time or the limit switches
// contradict each other.
module gate_arm_ctrl #(
   parameter int unsigned MOTOR_TIMEOUT = 50,
   parameter int unsigned HOLD_TIME     = 20,
   parameter int unsigned CNT_W         = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic Open_1,
   input  logic Full,
   input  logic Closed,
   input  logic Override,
   input  logic Car_Req,
   input  logic Beam,
   input  logic Lim_Up,
   input  logic Lim_Down,
   output logic Up,
   output logic Down,
   output logic Gate_Fault,
   output logic Gate_Busy
);

   typedef enum logic [2:0] {
      S_DOWN_IDLE = 3'd0,
      S_RAISING   = 3'd1,
      S_HELD_UP   = 3'd2,
      S_LOWERING  = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LP_MOTOR_TIMEOUT = CNT_W'(MOTOR_TIMEOUT);
   localparam logic [CNT_W-1:0] LP_HOLD_TIME     = CNT_W'(HOLD_TIME);

   state_t           r_state;
   logic [CNT_W-1:0] r_timer;
   logic             r_up;
   logic             r_down;
   logic             r_fault;
   logic             r_busy;

   state_t           w_next_state;
   logic [CNT_W-1:0] w_timer_next;
   logic [CNT_W-1:0] w_timer_inc;
   logic             w_permit;
   logic             w_sensor_fault;
   logic             w_hold;
   logic             w_motor_expired;
   logic             w_hold_expired;

   // Decode of the raw inputs and the saturating timer increment.
   // Expiry compares the value the timer would take this cycle, so a move
   // that started on edge N faults on edge N+MOTOR_TIMEOUT.
   always_comb begin
      w_permit        = Override | (Car_Req & Open_1 & ~Full & ~Closed);
      w_sensor_fault  = Lim_Up & Lim_Down;
      w_hold          = Beam | Car_Req | Override;
      w_timer_inc     = (r_timer == '1) ? r_timer : r_timer + 1'b1;
      w_motor_expired = (w_timer_inc >= LP_MOTOR_TIMEOUT);
      w_hold_expired  = (w_timer_inc >= LP_HOLD_TIME);
   end

   // Next-state and next-timer selection; every state change clears the timer.
   always_comb begin
      w_next_state = r_state;
      w_timer_next = w_timer_inc;
      if (w_sensor_fault) begin
         // Contradictory limit switches override whatever the arm is doing.
         w_next_state = S_FAULT;
         w_timer_next = '0;
      end else begin
         case (r_state)
            S_DOWN_IDLE: begin
               // Lot status is only honoured here; a car cycle in progress
               // always completes even if Full/Closed rise meanwhile.
               w_timer_next = '0;
               if (w_permit) begin
                  w_next_state = S_RAISING;
               end
            end
            S_RAISING: begin
               if (Lim_Up) begin
                  w_next_state = S_HELD_UP;
                  w_timer_next = '0;
               end else if (w_motor_expired) begin
                  w_next_state = S_FAULT;
                  w_timer_next = '0;
               end
            end
            S_HELD_UP: begin
               if (w_hold) begin
                  w_timer_next = '0;
               end else if (w_hold_expired) begin
                  w_next_state = S_LOWERING;
                  w_timer_next = '0;
               end
            end
            S_LOWERING: begin
               // Obstruction reverse outranks reaching the down limit.
               if (Beam | Override) begin
                  w_next_state = S_RAISING;
                  w_timer_next = '0;
               end else if (Lim_Down) begin
                  w_next_state = S_DOWN_IDLE;
                  w_timer_next = '0;
               end else if (w_motor_expired) begin
                  w_next_state = S_FAULT;
                  w_timer_next = '0;
               end
            end
            S_FAULT: begin
               w_timer_next = '0;
            end
            default: begin
               w_next_state = S_FAULT;
               w_timer_next = '0;
            end
         endcase
      end
   end

   // State, timer and outputs registered together; outputs are decoded from
   // the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_DOWN_IDLE;
         r_timer <= '0;
         r_up    <= 1'b0;
         r_down  <= 1'b0;
         r_fault <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_timer <= w_timer_next;
         r_up    <= (w_next_state == S_RAISING);
         r_down  <= (w_next_state == S_LOWERING);
         r_fault <= (w_next_state == S_FAULT);
         r_busy  <= (w_next_state != S_DOWN_IDLE);
      end
   end

   assign Up         = r_up;
   assign Down       = r_down;
   assign Gate_Fault = r_fault;
   assign Gate_Busy  = r_busy;

endmodule

// File: tb/tb_gate_arm_ctrl.sv
// tb_gate_arm_ctrl: directed self-checking bench for gate_arm_ctrl.
module tb_gate_arm_ctrl;

   localparam int unsigned MT = 50;
   localparam int unsigned HT = 20;

   logic clk = 1'b0;
   logic rst, Open_1, Full, Closed, Override, Car_Req, Beam, Lim_Up, Lim_Down;
   logic Up, Down, Gate_Fault, Gate_Busy;

   int n_checks = 0;
   int n_pass   = 0;

   gate_arm_ctrl #(.MOTOR_TIMEOUT(MT), .HOLD_TIME(HT), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .Open_1(Open_1), .Full(Full), .Closed(Closed),
      .Override(Override), .Car_Req(Car_Req), .Beam(Beam),
      .Lim_Up(Lim_Up), .Lim_Down(Lim_Down),
      .Up(Up), .Down(Down), .Gate_Fault(Gate_Fault), .Gate_Busy(Gate_Busy)
   );

   always #5 clk = ~clk;

   // Motor commands must never both be on, checked every cycle.
   always @(negedge clk) begin
      n_checks++;
      assert ((Up & Down) === 1'b0) n_pass++;
      else $error("FAIL up_down_exclusive: Up=%b Down=%b required not both 1", Up, Down);
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic up, input logic dn,
                          input logic flt, input logic bsy);
      chk({tag, ".Up"}, Up, up);
      chk({tag, ".Down"}, Down, dn);
      chk({tag, ".Fault"}, Gate_Fault, flt);
      chk({tag, ".Busy"}, Gate_Busy, bsy);
   endtask

   // Advance one clock edge; outputs are then sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; Open_1 = 1'b0; Full = 1'b0; Closed = 1'b0; Override = 1'b0;
      Car_Req = 1'b0; Beam = 1'b0; Lim_Up = 1'b0; Lim_Down = 1'b1;
      step();
      step();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // ---- 1: normal car cycle
      Open_1 = 1'b1; Car_Req = 1'b1;
      step();
      chk_all("t1_raise", 1'b1, 1'b0, 1'b0, 1'b1);
      Car_Req = 1'b0; Lim_Down = 1'b0;
      step();
      step();
      chk("t1_still_raising", Up, 1'b1);
      Lim_Up = 1'b1;
      step();
      chk_all("t1_held", 1'b0, 1'b0, 1'b0, 1'b1);
      Beam = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk_all("t1_beam_hold", 1'b0, 1'b0, 1'b0, 1'b1);
      Beam = 1'b0;
      for (int i = 0; i < 19; i++) step();
      chk("t1_hold_19", Down, 1'b0);
      step();
      chk_all("t1_lower_20", 1'b0, 1'b1, 1'b0, 1'b1);
      Lim_Up = 1'b0;
      step();
      chk("t1_lowering", Down, 1'b1);
      Lim_Down = 1'b1;
      step();
      chk_all("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // ---- 2: status blocks entry, override forces it
      Full = 1'b1; Car_Req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         chk("t2_full_block", Up, 1'b0);
      end
      Full = 1'b0; Closed = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         chk("t2_closed_block", Up, 1'b0);
      end
      chk("t2_closed_busy", Gate_Busy, 1'b0);
      Override = 1'b1;
      step();
      chk_all("t2_override", 1'b1, 1'b0, 1'b0, 1'b1);
      Lim_Down = 1'b0; Lim_Up = 1'b1;
      step();
      chk("t2_held", Up, 1'b0);
      for (int i = 0; i < 30; i++) step();
      chk("t2_override_holds", Down, 1'b0);
      Override = 1'b0; Car_Req = 1'b0; Closed = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk_all("t2_lower", 1'b0, 1'b1, 1'b0, 1'b1);
      Lim_Up = 1'b0;

      // ---- 3: safety reverse
      Beam = 1'b1;
      step();
      chk_all("t3_reverse", 1'b1, 1'b0, 1'b0, 1'b1);
      Beam = 1'b0;
      step();
      chk("t3_raising", Up, 1'b1);
      Lim_Up = 1'b1;
      step();
      chk("t3_held", Up, 1'b0);
      Lim_Up = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("t3_lower_again", Down, 1'b1);
      Beam = 1'b1; Lim_Down = 1'b1;
      step();
      chk_all("t3_reverse_wins", 1'b1, 1'b0, 1'b0, 1'b1);
      Beam = 1'b0; Lim_Down = 1'b0; Lim_Up = 1'b1;
      step();
      Lim_Up = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("t3_lower_final", Down, 1'b1);
      Lim_Down = 1'b1;
      step();
      chk_all("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // ---- 4: raise timeout
      Car_Req = 1'b1;
      step();
      chk("t4_up_rose", Up, 1'b1);
      Car_Req = 1'b0; Lim_Down = 1'b0;
      for (int i = 1; i < 50; i++) step();
      chk_all("t4_cycle49", 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      chk_all("t4_timeout50", 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         Override = i[0];
         Car_Req  = ~i[0];
         step();
         chk("t4_fault_sticky", Gate_Fault, 1'b1);
         chk("t4_fault_no_up", Up, 1'b0);
      end
      Override = 1'b0; Car_Req = 1'b0; Lim_Down = 1'b1;
      rst = 1'b1;
      step();
      chk_all("t4_rst_clears", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // ---- 5: sensor fault and reset mid-motion
      Car_Req = 1'b1;
      step();
      chk("t5_raise", Up, 1'b1);
      Car_Req = 1'b0; Lim_Down = 1'b0; Lim_Up = 1'b1;
      step();
      chk_all("t5_held", 1'b0, 1'b0, 1'b0, 1'b1);
      Lim_Down = 1'b1;
      step();
      chk_all("t5_sensor_fault", 1'b0, 1'b0, 1'b1, 1'b1);
      Lim_Up = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_fault_cleared", Gate_Fault, 1'b0);
      Car_Req = 1'b1;
      step();
      chk("t5_raise2", Up, 1'b1);
      Lim_Down = 1'b0;
      step();
      chk("t5_raising2", Up, 1'b1);
      rst = 1'b1;
      step();
      chk_all("t5_rst_mid_raise", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("t5_rst_held", Up, 1'b0);
      rst = 1'b0; Car_Req = 1'b0; Lim_Down = 1'b1;
      step();
      chk_all("t5_no_motion", 1'b0, 1'b0, 1'b0, 1'b0);
      Car_Req = 1'b1;
      step();
      chk("t5_permit_resampled", Up, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
